// File: rtl/booth_mult_if.sv
// Handshake and operand/result bundle for the Booth multiplier core.
// Ports: start/mcand/mplier from requester; busy/done/product from core.
interface booth_mult_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, mcand, mplier,
        input  busy, done, product
    );

    modport slave (
        input  start, mcand, mplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mult_core.sv
// Radix-2 Booth sequential signed multiplier, one iteration per clock.
// Ports: clk1, rst_n (async low); bus.slave: start/mcand/mplier in, busy/done/product out.
module booth_mult_core #(
    parameter int WIDTH = 8
) (
    input  logic          clk1,
    input  logic          rst_n,
    booth_mult_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH:0]       a_nxt;
    logic [WIDTH:0]       a_sh;
    logic [WIDTH-1:0]     q_sh;

    // Booth recoding on {Q[0],Q_1}; A carries a guard bit so -M is exact
    // even for the most negative multiplicand.
    always_comb begin
        unique case ({q_q[0], q1_q})
            2'b10:   a_nxt = a_q - m_q;
            2'b01:   a_nxt = a_q + m_q;
            default: a_nxt = a_q;
        endcase
    end

    // Arithmetic right shift of {A',Q,Q_1}
    assign a_sh = {a_nxt[WIDTH], a_nxt[WIDTH:1]};
    assign q_sh = {a_nxt[0], q_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        prod_d  = prod_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (bus.start) begin
                    m_d     = {bus.mcand[WIDTH-1], bus.mcand};
                    q_d     = bus.mplier;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_sh;
                q_d   = q_sh;
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    prod_d  = {a_sh[WIDTH-1:0], q_sh};
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = prod_q;
endmodule

// File: tb/tb_booth_mult_core.sv
// Scoreboard bench for booth_mult_core: random and directed signed multiplies.
// Expected products come from plain integer multiplication of the accepted operands.
module tb_booth_mult_core;
    localparam int W = 8;

    logic clk1  = 1'b0;
    logic rst_n = 1'b1;

    booth_mult_if #(.WIDTH(W)) bus ();

    booth_mult_core #(.WIDTH(W)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc++;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2*W-1:0] exp;
        int             acc;
    } exp_t;

    exp_t           sbq[$];
    bit             mon_en    = 1'b0;
    bit             prev_done = 1'b0;
    logic [2*W-1:0] last_prod = '0;

    function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b);
        int r;
        r = int'($signed(a)) * int'($signed(b));
        return r[2*W-1:0];
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, pops expectations on done,
    // and records newly accepted requests.
    always @(negedge clk1) begin
        if (!rst_n) begin
            sbq.delete();
            last_prod = '0;
            prev_done = 1'b0;
        end else if (mon_en) begin
            if (prev_done)
                check("busy_fall", 32'(bus.busy), 32'd0);
            if (bus.done) begin
                check("done_width", 32'(prev_done), 32'd0);
                check("done_expected", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("product", 32'(bus.product), 32'(e.exp));
                    check("latency", 32'(cyc - e.acc), 32'(W));
                end
                last_prod = bus.product;
            end else begin
                check("product_hold", 32'(bus.product), 32'(last_prod));
                if (sbq.size() > 0 && (cyc - sbq[0].acc) > W + 1) begin
                    check("done_timeout", 32'(cyc - sbq[0].acc), 32'(W));
                    void'(sbq.pop_front());
                end
            end
            prev_done = bus.done;
            if (bus.start && !bus.busy) begin
                exp_t n;
                n.exp = ref_mul(bus.mcand, bus.mplier);
                n.acc = cyc + 1;
                sbq.push_back(n);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 2 * W + 4 && bus.busy; i++) begin
            @(posedge clk1);
            #2;
        end
        if (bus.busy)
            check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic op(logic [W-1:0] mc, logic [W-1:0] mp,
                      bit chk, logic [2*W-1:0] exp);
        @(posedge clk1);
        #2;
        bus.start  = 1'b1;
        bus.mcand  = mc;
        bus.mplier = mp;
        @(posedge clk1);
        #2;
        bus.start  = 1'b0;
        bus.mcand  = W'($urandom);
        bus.mplier = W'($urandom);
        wait_idle();
        if (chk)
            check("directed", 32'(bus.product), 32'(exp));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start  = 1'b0;
        bus.mcand  = '0;
        bus.mplier = '0;

        #13 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_product", 32'(bus.product), 32'd0);
        @(posedge clk1);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(posedge clk1);
        #2;
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_product", 32'(bus.product), 32'd0);

        op(8'h03, 8'h05, 1'b1, 16'h000F);
        op(8'hFD, 8'h05, 1'b1, 16'hFFF1);
        op(8'h80, 8'h80, 1'b1, 16'h4000);
        op(8'h7F, 8'h80, 1'b1, 16'hC080);
        op(8'h00, 8'hA5, 1'b1, 16'h0000);
        op(8'h7F, 8'h7F, 1'b1, 16'h3F01);
        op(8'h80, 8'h7F, 1'b1, 16'hC080);

        // start held high with operands moving every cycle
        @(posedge clk1);
        #2;
        for (int i = 0; i < 25; i++) begin
            bus.start  = 1'b1;
            bus.mcand  = W'($urandom);
            bus.mplier = W'($urandom);
            @(posedge clk1);
            #2;
        end
        bus.start = 1'b0;
        wait_idle();

        // reset in the middle of a run
        @(posedge clk1);
        #2;
        bus.start  = 1'b1;
        bus.mcand  = 8'h03;
        bus.mplier = 8'h05;
        @(posedge clk1);
        #2;
        bus.start = 1'b0;
        repeat (3) @(posedge clk1);
        #2;
        check("midrun_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_product", 32'(bus.product), 32'd0);
        @(posedge clk1);
        #2;
        rst_n = 1'b1;
        op(8'h02, 8'h02, 1'b1, 16'h0004);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk1);
            op(W'($urandom), W'($urandom), 1'b0, '0);
        end

        repeat (4) @(posedge clk1);
        #2;
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
